// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store path: access sizes, FSM states,
// byte-enable patterns and the lane helpers used to build bus requests.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // size[1]=1 means word for both 2'b10 and 2'b11.
   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
      if (size[1])
         return BE_WORD;
      else if (size == SZ_HALF)
         return BE_HALF << {lo[1], 1'b0};
      else
         return BE_BYTE << lo;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      if (size[1])
         return wdata;
      else if (size == SZ_HALF)
         return {2{wdata[15:0]}};
      else
         return {4{wdata[7:0]}};
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      if (size[1])
         return lo != 2'b00;
      else if (size == SZ_HALF)
         return lo[0];
      else
         return 1'b0;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane select and sign/zero extension of a bus read word.
// Shared by the MEM-stage access unit and future cache fill logic.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lo,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   output logic [31:0] data
);

   logic [15:0] half_lane;
   logic [7:0]  byte_lane;

   always_comb begin
      half_lane = lo[1] ? rdata[31:16] : rdata[15:0];
      byte_lane = rdata[7:0];
      case (lo)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
   end

   // Word loads pass through untouched; the unsigned bit only matters for narrower sizes.
   always_comb begin
      data = rdata;
      if (size[1])
         data = rdata;
      else if (size == SZ_HALF)
         data = {{16{~unsigned_ld & half_lane[15]}}, half_lane};
      else
         data = {{24{~unsigned_ld & byte_lane[7]}}, byte_lane};
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one bus transaction per memory instruction,
// stalling the pipeline until it completes. Optional macro: MEM_MISALIGN_CHK_EN.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_re_i,
   input  logic              mem_we_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [31:0]       bus_wdata_o,
   input  logic [31:0]       bus_rdata_i,
   input  logic              bus_ack_i,
`ifdef MEM_MISALIGN_CHK_EN
   output logic              misalign_o,
`endif
   output logic [31:0]       rdata_o,
   output logic              rdata_valid_o,
   output logic              stall_o
);

   // Bus handshake: bus_req_o rises on the edge leaving IDLE and stays high with
   // addr/be/we/wdata frozen until the first cycle bus_ack_i=1 is seen with it;
   // that edge completes the access. Ack outside a request is ignored.

   state_t      state_q, state_d;
   logic        start;
   logic        access_misal;
   logic        misal_q;
   logic        load_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [31:0] ld_data;

`ifdef MEM_MISALIGN_CHK_EN
   assign access_misal = is_misaligned(funct3_i[1:0], addr_i[1:0]);
`else
   assign access_misal = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_re_i | mem_we_i) begin
               stall_o = 1'b1;
               start   = 1'b1;
               state_d = access_misal ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            stall_o = 1'b1;
            if (bus_ack_i)
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   mem_load_align u_load_align (
      .rdata       (bus_rdata_i),
      .lo          (lo_q),
      .size        (f3_q[1:0]),
      .unsigned_ld (f3_q[2]),
      .data        (ld_data)
   );

   // Everything the access needs is latched at start, so upstream changes are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= 4'b0000;
         bus_wdata_o <= 32'h0;
         rdata_o     <= 32'h0;
         load_q      <= 1'b0;
         misal_q     <= 1'b0;
         f3_q        <= 3'b000;
         lo_q        <= 2'b00;
      end else begin
         state_q <= state_d;
         if (start) begin
            bus_req_o   <= ~access_misal;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus_be_o    <= byte_enable(funct3_i[1:0], addr_i[1:0]);
            bus_wdata_o <= store_data(funct3_i[1:0], wdata_i);
            load_q      <= mem_re_i & ~mem_we_i;
            misal_q     <= access_misal;
            f3_q        <= funct3_i;
            lo_q        <= addr_i[1:0];
         end else if (state_q == S_REQ && bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (load_q)
               rdata_o <= ld_data;
         end
      end
   end

   assign rdata_valid_o = (state_q == S_DONE) & load_q & ~misal_q;

`ifdef MEM_MISALIGN_CHK_EN
   assign misalign_o = (state_q == S_DONE) & misal_q;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. Sits directly downstream of the EX/MEM pipeline register and consumes its ALU result (address), rD2 (store data), DRAM write enable and the load/store controls.
- Runs a req/ack transaction on the data bus (DRAM plus on-board peripherals) and does byte-lane steering and load extension.
- Drives stall_o to freeze PC/IF/ID/EX/MEM registers while a bus access is outstanding.
- Feeds load data to the MEM/WB register.

Parameters:
- ADDR_W, 32, width of addr_i and bus_addr_o.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- mem_re_i  input  1  load in MEM stage
- mem_we_i  input  1  store in MEM stage (EX/MEM dram_we)
- funct3_i  input  3  RISC-V funct3: [1:0] size (00 byte, 01 half, 1x word), [2] unsigned load
- addr_i  input  ADDR_W  effective address (EX/MEM alu_c)
- wdata_i  input  32  store data (EX/MEM rD2)
- bus_req_o  output  1  bus request, registered
- bus_we_o  output  1  bus write, registered
- bus_addr_o  output  ADDR_W  word address {addr_i[ADDR_W-1:2],2'b00}, registered
- bus_be_o  output  4  byte enables, registered
- bus_wdata_o  output  32  lane-replicated store data, registered
- bus_rdata_i  input  32  bus read word
- bus_ack_i  input  1  bus completion, valid only while bus_req_o=1
- rdata_o  output  32  extended load data to MEM/WB
- rdata_valid_o  output  1  rdata_o updated this cycle
- stall_o  output  1  freeze upstream pipeline registers

Behaviour:
- Reset is decided as: rst_n, asynchronous, active-low; clock is clk.
- On reset: state IDLE and all registered outputs 0. bus_req_o drops immediately, mid-transaction included; the outstanding access is abandoned.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If mem_re_i|mem_we_i, go to REQ and register bus_addr/be/we/wdata.
  - stall_o=1 combinationally in this cycle.
  - Otherwise stay in IDLE with stall_o=0; non-memory instructions pass with no stall.
- REQ:
  - bus_req_o=1; all bus outputs held stable; stall_o=1.
  - On bus_ack_i: go to DONE. For a load, capture the extended bus_rdata_i into rdata_o.
  - With no ack, wait indefinitely; there is no timeout.
- DONE:
  - bus_req_o=0, stall_o=0, so the pipeline advances at this edge. rdata_valid_o=1 if the access was a load.
  - Always return to IDLE. No new access starts in DONE, because the inputs still carry the completed instruction.
- Latency: 3 cycles minimum per memory instruction (ack in the first REQ cycle); each wait cycle adds 1.
- Upstream holds all inputs stable while stall_o=1. Input changes mid-access are ignored, since the bus outputs are latched.
- If mem_re_i and mem_we_i are both 1, the store takes priority and rdata_valid_o stays 0.
- bus_ack_i is ignored in IDLE and DONE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata as is
- Load data:
  - Select the lane by addr[1:0] (half uses addr[1]).
  - Sign-extend if funct3[2]=0, zero-extend if funct3[2]=1.
  - Word loads ignore funct3[2].
- rdata_o holds its value until the next load completes.
- Misaligned addresses with the optional feature off: the low bits are silently dropped (addr[0] for half, addr[1:0] for word).

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- When defined:
  - Adds output misalign_o (1 bit).
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request: IDLE goes straight to DONE.
  - In DONE: misalign_o=1, rdata_valid_o=0, rdata_o unchanged. Total 2 cycles.
- When undefined: no port, and misaligned accesses are forced aligned as above.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state encodings S_IDLE/S_REQ/S_DONE
  - byte-enable constants
- Sub-module mem_load_align: combinational lane select plus sign/zero extension, shared with future cache fill logic.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, ack in the first REQ cycle -> bus_be=1111, bus_addr=0x104, bus_we=1; stall_o high for 2 cycles, then low in DONE; total 3 cycles.
- SB addr=0x203, wdata=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5.
- LB addr=0x101, rdata_i=0x0000_80_00 -> rdata_o=0xFFFFFF80, rdata_valid_o=1 in DONE. Same access as LBU -> 0x00000080.
- LHU addr=0x102, rdata_i=0xBEEF1234, ack after 4 wait cycles -> stall_o high for 6 cycles, rdata_o=0x0000BEEF.
- Assert rst_n=0 while in REQ -> bus_req_o=0 and stall_o=0 immediately; after release, IDLE with no spurious rdata_valid_o.
- With MEM_MISALIGN_CHK_EN, LW addr=0x102 -> no bus_req_o, misalign_o=1 for 1 cycle; without the macro -> bus_addr=0x100, be=1111.
